// File: rtl/muxn_pipe.sv
// -----------------------------------------------------------------------------
// muxn_pipe -- pipelined N:1 word multiplexer built as a binary 2:1-mux tree.
//
// The tree has SEL_W = $clog2(NUM_IN) levels. Level k (k = 0 at the leaves)
// uses select bit k, so the LSB of in_sel is consumed first. Each level is
// followed by a register stage holding the partial words, the select bits
// still to be used and a valid bit. The latency from accept to out_valid is
// exactly SEL_W cycles. Leaves beyond NUM_IN are constant zero, so any
// in_sel >= NUM_IN produces out_data = 0.
//
// Handshake: a word is accepted on a cycle with in_valid && in_ready, and a
// result is consumed on a cycle with out_valid && out_ready. Stage k loads
// when it is empty or when stage k+1 loads (the last stage loads when it is
// empty or its result is consumed), so bubbles collapse and the pipe streams
// one word per cycle while out_ready = 1. in_ready is the stage-0 load
// condition, combinational from out_ready, and forced low while rst = 1.
//
// Optional feature: define MUXN_PIPE_OOR_FLAG_EN to add port out_err, a
// per-transaction "select out of range" flag (in_sel >= NUM_IN) captured at
// acceptance and carried alongside the data. It reads 0 whenever
// out_valid = 0 and is constant 0 when NUM_IN is a power of two.
//
// Parameters:
//   WIDTH   bit width of each data word (>= 1)
//   NUM_IN  number of input words (>= 2)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (clears valid bits only)
//   in_valid   input transaction present
//   in_ready   block accepts input this cycle
//   in_data    NUM_IN words, word i at bits [i*WIDTH +: WIDTH]
//   in_sel     index of the word to select
//   out_valid  out_data holds a result
//   out_ready  consumer accepts the result
//   out_data   selected word
//   out_err    select was out of range (only with MUXN_PIPE_OOR_FLAG_EN)
// -----------------------------------------------------------------------------
module muxn_pipe #(
    parameter  int WIDTH  = 8,
    parameter  int NUM_IN = 4,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data
`ifdef MUXN_PIPE_OOR_FLAG_EN
    ,
    output logic                    out_err
`endif
);

    // Number of leaves of the full binary tree.
    localparam int PADDED = 1 << SEL_W;

    // Input words extended with constant-zero leaves up to PADDED words.
    logic [PADDED*WIDTH-1:0] w_in_pad;

    if (PADDED > NUM_IN) begin : g_pad
        assign w_in_pad = {{((PADDED - NUM_IN) * WIDTH){1'b0}}, in_data};
    end else begin : g_nopad
        assign w_in_pad = in_data;
    end

`ifdef MUXN_PIPE_OOR_FLAG_EN
    logic w_oor;

    // With a power-of-two NUM_IN every select value addresses a real word.
    if (PADDED == NUM_IN) begin : g_oor_const
        assign w_oor = 1'b0;
    end else begin : g_oor_cmp
        assign w_oor = (in_sel >= SEL_W'(NUM_IN));
    end
`endif

    for (genvar k = 0; k < SEL_W; k++) begin : g_stage
        localparam int N_IN  = PADDED >> k;     // words entering this level
        localparam int N_OUT = N_IN / 2;        // words leaving this level
        localparam int SR_W  = SEL_W - 1 - k;   // select bits still unused

        logic [N_IN*WIDTH-1:0]  w_words;
        logic                   w_s;
        logic                   w_up_valid;
        logic                   w_load;
        logic [N_OUT*WIDTH-1:0] w_mux;
        logic [N_OUT*WIDTH-1:0] r_words;
        logic                   r_valid;
`ifdef MUXN_PIPE_OOR_FLAG_EN
        logic                   w_up_err;
        logic                   r_err;
`endif

        // Upstream source: the module inputs for level 0, otherwise the
        // register stage of the previous level.
        if (k == 0) begin : g_src_in
            assign w_words    = w_in_pad;
            assign w_s        = in_sel[0];
            assign w_up_valid = in_valid;
`ifdef MUXN_PIPE_OOR_FLAG_EN
            assign w_up_err   = w_oor;
`endif
        end else begin : g_src_prev
            assign w_words    = g_stage[k-1].r_words;
            assign w_s        = g_stage[k-1].g_sel.r_sel[0];
            assign w_up_valid = g_stage[k-1].r_valid;
`ifdef MUXN_PIPE_OOR_FLAG_EN
            assign w_up_err   = g_stage[k-1].r_err;
`endif
        end

        // Bubble-collapsing load: a stage may take new contents when it is
        // empty or when its own contents move downstream this cycle.
        if (k == SEL_W - 1) begin : g_load_last
            assign w_load = ~r_valid | out_ready;
        end else begin : g_load_mid
            assign w_load = ~r_valid | g_stage[k+1].w_load;
        end

        // 2:1 muxes written as ((a ^ b) & s) ^ a: one AND per output bit.
        for (genvar j = 0; j < N_OUT; j++) begin : g_mux
            logic [WIDTH-1:0] w_a;
            logic [WIDTH-1:0] w_b;

            assign w_a = w_words[(2*j)*WIDTH +: WIDTH];
            assign w_b = w_words[(2*j+1)*WIDTH +: WIDTH];
            assign w_mux[j*WIDTH +: WIDTH] = ((w_a ^ w_b) & {WIDTH{w_s}}) ^ w_a;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_valid <= 1'b0;
            end else if (w_load) begin
                r_valid <= w_up_valid;
            end
        end

        // Payload registers are not reset; their content is qualified by
        // r_valid everywhere it is observed.
        always_ff @(posedge clk) begin
            if (w_load) begin
                r_words <= w_mux;
`ifdef MUXN_PIPE_OOR_FLAG_EN
                r_err   <= w_up_err;
`endif
            end
        end

        // Select bits for the levels below; the last stage needs none.
        if (SR_W > 0) begin : g_sel
            logic [SR_W-1:0] r_sel;
            logic [SR_W-1:0] w_sel_nxt;

            if (k == 0) begin : g_sel_in
                assign w_sel_nxt = in_sel[SEL_W-1:1];
            end else begin : g_sel_prev
                assign w_sel_nxt = g_stage[k-1].g_sel.r_sel[SR_W:1];
            end

            always_ff @(posedge clk) begin
                if (w_load) begin
                    r_sel <= w_sel_nxt;
                end
            end
        end
    end

    // Reset blocks acceptance outright so nothing enters a pipe being flushed.
    assign in_ready  = g_stage[0].w_load & ~rst;
    assign out_valid = g_stage[SEL_W-1].r_valid;
    assign out_data  = g_stage[SEL_W-1].r_words;
`ifdef MUXN_PIPE_OOR_FLAG_EN
    assign out_err   = g_stage[SEL_W-1].r_valid & g_stage[SEL_W-1].r_err;
`endif

endmodule

// File: tb/tb_muxn_pipe.sv
// -----------------------------------------------------------------------------
// tb_muxn_pipe -- self-checking bench for muxn_pipe.
//
// Instances:
//   u_d4      WIDTH=8,  NUM_IN=4  (directed latency, streaming, stall, reset)
//   u_d5      WIDTH=8,  NUM_IN=5  (out-of-range selects, reset flush)
//   g_rnd[g]  WIDTH=13, NUM_IN in {2,3,7,8} (random valid/ready traffic)
//
// The reference model picks word `sel` of the input bus when sel < NUM_IN
// and zero otherwise; the expected latency is $clog2(NUM_IN) cycles.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// on the falling edge, where handshakes for the next rising edge are decided.
// -----------------------------------------------------------------------------
module tb_muxn_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    // ---------------- u_d4 : WIDTH 8, NUM_IN 4 ----------------
    logic        d4_in_valid, d4_in_ready, d4_out_valid, d4_out_ready;
    logic [31:0] d4_in_data;
    logic [1:0]  d4_in_sel;
    logic [7:0]  d4_out_data;
    logic        d4_out_err;

    muxn_pipe #(.WIDTH(8), .NUM_IN(4)) u_d4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (d4_in_valid),
        .in_ready  (d4_in_ready),
        .in_data   (d4_in_data),
        .in_sel    (d4_in_sel),
        .out_valid (d4_out_valid),
        .out_ready (d4_out_ready),
        .out_data  (d4_out_data)
`ifdef MUXN_PIPE_OOR_FLAG_EN
        ,
        .out_err   (d4_out_err)
`endif
    );

    // ---------------- u_d5 : WIDTH 8, NUM_IN 5 ----------------
    logic        d5_in_valid, d5_in_ready, d5_out_valid, d5_out_ready;
    logic [39:0] d5_in_data;
    logic [2:0]  d5_in_sel;
    logic [7:0]  d5_out_data;
    logic        d5_out_err;

    muxn_pipe #(.WIDTH(8), .NUM_IN(5)) u_d5 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (d5_in_valid),
        .in_ready  (d5_in_ready),
        .in_data   (d5_in_data),
        .in_sel    (d5_in_sel),
        .out_valid (d5_out_valid),
        .out_ready (d5_out_ready),
        .out_data  (d5_out_data)
`ifdef MUXN_PIPE_OOR_FLAG_EN
        ,
        .out_err   (d5_out_err)
`endif
    );

    // ---------------- random instances : WIDTH 13 ----------------
    logic [3:0]         r_in_valid, r_in_ready, r_out_valid, r_out_ready, r_out_err;
    logic [3:0][103:0]  r_in_data;
    logic [3:0][2:0]    r_in_sel;
    logic [3:0][12:0]   r_out_data;

    function automatic int rnd_num(input int d);
        case (d)
            0:       return 2;
            1:       return 3;
            2:       return 7;
            default: return 8;
        endcase
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_rnd
        localparam int N  = (g == 0) ? 2 : (g == 1) ? 3 : (g == 2) ? 7 : 8;
        localparam int SW = $clog2(N);

        muxn_pipe #(.WIDTH(13), .NUM_IN(N)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (r_in_valid[g]),
            .in_ready  (r_in_ready[g]),
            .in_data   (r_in_data[g][N*13-1:0]),
            .in_sel    (r_in_sel[g][SW-1:0]),
            .out_valid (r_out_valid[g]),
            .out_ready (r_out_ready[g]),
            .out_data  (r_out_data[g])
`ifdef MUXN_PIPE_OOR_FLAG_EN
            ,
            .out_err   (r_out_err[g])
`endif
        );
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] pick8(input logic [39:0] data, input int sel, input int n);
        if (sel < n) return data[sel*8 +: 8];
        return 8'h00;
    endfunction

    function automatic logic [12:0] pick13(input logic [103:0] data, input int sel, input int n);
        if (sel < n) return data[sel*13 +: 13];
        return 13'h0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        d4_in_valid = 1'b1;
        d4_out_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if (d4_in_ready !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_in_ready_low: got %b expected 0", d4_in_ready);
            end
            step();
        end
        rst = 1'b0;
        d4_in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (d4_out_valid !== 1'b0 || d4_in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_d4_state: got out_valid=%b in_ready=%b expected 0/1",
                     d4_out_valid, d4_in_ready);
        end
        n_checks++;
        if (d5_out_valid !== 1'b0 || d5_in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_d5_state: got out_valid=%b in_ready=%b expected 0/1",
                     d5_out_valid, d5_in_ready);
        end
        n_checks++;
        if (r_out_valid !== 4'h0 || r_in_ready !== 4'hf) begin
            n_errors++;
            $display("FAIL reset_rnd_state: got out_valid=%h in_ready=%h expected 0/f",
                     r_out_valid, r_in_ready);
        end
`ifdef MUXN_PIPE_OOR_FLAG_EN
        n_checks++;
        if (d4_out_err !== 1'b0 || d5_out_err !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_out_err: got %b/%b expected 0/0", d4_out_err, d5_out_err);
        end
`endif
        step();
    endtask

    // Single transactions on u_d4: out_valid must rise exactly 2 cycles after accept.
    task automatic test_latency();
        logic [31:0] data;
        logic [7:0]  exp;
        int          sel;
        for (int i = 0; i < 6; i++) begin
            if (i == 0) begin
                data = 32'h44332211;
                sel  = 2;
            end else begin
                data = $urandom();
                sel  = $urandom_range(0, 3);
            end
            exp = pick8({8'h00, data}, sel, 4);
            d4_in_valid  = 1'b1;
            d4_in_data   = data;
            d4_in_sel    = 2'(sel);
            d4_out_ready = 1'b1;
            @(negedge clk);
            n_checks++;
            if (d4_in_ready !== 1'b1) begin
                n_errors++;
                $display("FAIL lat_in_ready: got %b expected 1", d4_in_ready);
            end
            step();
            d4_in_valid = 1'b0;
            @(negedge clk);
            n_checks++;
            if (d4_out_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL lat_early: out_valid got %b expected 0 one cycle after accept", d4_out_valid);
            end
            step();
            @(negedge clk);
            n_checks++;
            if (d4_out_valid !== 1'b1 || d4_out_data !== exp) begin
                n_errors++;
                $display("FAIL lat_data: got valid=%b data=%h expected valid=1 data=%h (sel %0d)",
                         d4_out_valid, d4_out_data, exp, sel);
            end
`ifdef MUXN_PIPE_OOR_FLAG_EN
            n_checks++;
            if (d4_out_err !== 1'b0) begin
                n_errors++;
                $display("FAIL lat_err: got %b expected 0", d4_out_err);
            end
`endif
            step();
        end
    endtask

    // u_d5: selects beyond NUM_IN yield zero (and the flag), latency 3.
    task automatic test_oor();
        int          sels[8] = '{6, 4, 5, 7, 0, 3, 1, 2};
        logic [39:0] data;
        logic [7:0]  exp;
        int          lat;
        for (int i = 0; i < 8; i++) begin
            data = {$urandom_range(1, 255), $urandom()};
            exp  = pick8(data, sels[i], 5);
            d5_in_valid  = 1'b1;
            d5_in_data   = data;
            d5_in_sel    = 3'(sels[i]);
            d5_out_ready = 1'b1;
            @(negedge clk);
            n_checks++;
            if (d5_in_ready !== 1'b1) begin
                n_errors++;
                $display("FAIL oor_in_ready: got %b expected 1", d5_in_ready);
            end
            step();
            d5_in_valid = 1'b0;
            lat = 0;
            while (lat < 8) begin
                @(negedge clk);
                lat++;
                if (d5_out_valid === 1'b1) break;
                step();
            end
            n_checks++;
            if (d5_out_valid !== 1'b1 || lat != 3) begin
                n_errors++;
                $display("FAIL oor_latency: got valid=%b after %0d cycles expected valid=1 after 3",
                         d5_out_valid, lat);
            end
            n_checks++;
            if (d5_out_data !== exp) begin
                n_errors++;
                $display("FAIL oor_data: sel %0d got %h expected %h", sels[i], d5_out_data, exp);
            end
`ifdef MUXN_PIPE_OOR_FLAG_EN
            n_checks++;
            if (d5_out_err !== (sels[i] >= 5)) begin
                n_errors++;
                $display("FAIL oor_err: sel %0d got %b expected %b", sels[i], d5_out_err, sels[i] >= 5);
            end
`endif
            step();
        end
    endtask

    // u_d4: four back-to-back selects must come out on four consecutive cycles.
    task automatic test_back_to_back();
        logic [7:0]  exp_q[$];
        logic [31:0] data;
        int          got, first_c, last_c;
        data = $urandom();
        got = 0;
        first_c = -1;
        last_c = -1;
        d4_out_ready = 1'b1;
        d4_in_data   = data;
        for (int c = 0; c < 10; c++) begin
            d4_in_valid = (c < 4);
            d4_in_sel   = 2'(c % 4);
            @(negedge clk);
            if (c < 4) begin
                n_checks++;
                if (d4_in_ready !== 1'b1) begin
                    n_errors++;
                    $display("FAIL b2b_in_ready: cycle %0d got %b expected 1", c, d4_in_ready);
                end
                exp_q.push_back(pick8({8'h00, data}, c, 4));
            end
            if (d4_out_valid === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL b2b_extra: got %h expected no result", d4_out_data);
                end else if (d4_out_data !== exp_q[0]) begin
                    n_errors++;
                    $display("FAIL b2b_data: got %h expected %h", d4_out_data, exp_q[0]);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
                got++;
                if (first_c < 0) first_c = c;
                last_c = c;
            end
            step();
        end
        d4_in_valid = 1'b0;
        n_checks++;
        if (got != 4 || last_c - first_c != 3) begin
            n_errors++;
            $display("FAIL b2b_throughput: got %0d results over cycles %0d..%0d expected 4 consecutive",
                     got, first_c, last_c);
        end
    endtask

    // u_d4: stall the output; exactly 2 enter, output holds, then both drain in order.
    task automatic test_backpressure();
        logic [7:0] exp_q[$];
        logic [7:0] held;
        bit         have_held;
        int         acc, stab_err, got, sel;
        acc = 0; stab_err = 0; got = 0; have_held = 0; held = '0;
        d4_out_ready = 1'b0;
        d4_in_valid  = 1'b1;
        d4_in_data   = $urandom();
        d4_in_sel    = 2'($urandom_range(0, 3));
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (d4_out_valid === 1'b1) begin
                if (!have_held) begin
                    held = d4_out_data;
                    have_held = 1;
                end else if (d4_out_data !== held) begin
                    stab_err++;
                end
            end
            if (d4_in_ready === 1'b1) begin
                sel = int'(d4_in_sel);
                exp_q.push_back(pick8({8'h00, d4_in_data}, sel, 4));
                acc++;
                step();
                d4_in_data = $urandom();
                d4_in_sel  = 2'($urandom_range(0, 3));
            end else begin
                step();
            end
        end
        n_checks++;
        if (acc != 2) begin
            n_errors++;
            $display("FAIL bp_accepted: got %0d expected 2", acc);
        end
        n_checks++;
        if (!have_held || stab_err != 0) begin
            n_errors++;
            $display("FAIL bp_stable: seen=%0d unstable cycles=%0d expected seen=1 unstable=0",
                     have_held, stab_err);
        end
        d4_in_valid  = 1'b0;
        d4_out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (d4_out_valid === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL bp_extra: got %h expected no result", d4_out_data);
                end else if (d4_out_data !== exp_q[0]) begin
                    n_errors++;
                    $display("FAIL bp_drain_data: got %h expected %h", d4_out_data, exp_q[0]);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
                got++;
            end
            step();
        end
        n_checks++;
        if (got != 2) begin
            n_errors++;
            $display("FAIL bp_drain_count: got %0d expected 2", got);
        end
    endtask

    // u_d5: two accepted, reset the cycle before the first would emerge.
    task automatic test_reset_flush();
        int seen;
        d5_out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            d5_in_valid = 1'b1;
            d5_in_data  = {$urandom_range(1, 255), $urandom()};
            d5_in_sel   = 3'(c);
            @(negedge clk);
            n_checks++;
            if (d5_in_ready !== 1'b1) begin
                n_errors++;
                $display("FAIL flush_accept: cycle %0d in_ready got %b expected 1", c, d5_in_ready);
            end
            step();
        end
        d5_in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (d5_in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_in_ready_rst: got %b expected 0", d5_in_ready);
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (d5_out_valid !== 1'b0 || d5_in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL flush_after_rst: got out_valid=%b in_ready=%b expected 0/1",
                     d5_out_valid, d5_in_ready);
        end
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            @(negedge clk);
            if (d5_out_valid !== 1'b0) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_errors++;
            $display("FAIL flush_ghost: got %0d cycles with out_valid expected 0", seen);
        end
        step();
    endtask

    // Random valid/ready traffic on each WIDTH=13 instance against the model.
    task automatic test_random();
        localparam int NT     = 2500;
        localparam int BUDGET = 20000;
        logic [13:0]  exp_q[$];
        logic [13:0]  got_w;
        logic [127:0] rnd;
        logic [12:0]  held;
        int           n, sw, sent, recv, cyc, hold_err, flight_err, ghost, sel;
        bit           stalled, accepted;
        for (int d = 0; d < 4; d++) begin
            n = rnd_num(d);
            sw = $clog2(n);
            sent = 0; recv = 0; cyc = 0; hold_err = 0; flight_err = 0;
            stalled = 0; held = '0;
            exp_q.delete();
            while (recv < NT && cyc < BUDGET) begin
                if (r_in_valid[d] !== 1'b1 && sent < NT && $urandom_range(0, 3) != 0) begin
                    rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
                    r_in_data[d]  = rnd[103:0];
                    r_in_sel[d]   = 3'($urandom_range(0, (1 << sw) - 1));
                    r_in_valid[d] = 1'b1;
                end
                r_out_ready[d] = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                if (exp_q.size() > sw) flight_err++;
                if (stalled && (r_out_valid[d] !== 1'b1 || r_out_data[d] !== held)) hold_err++;
                accepted = (r_in_valid[d] === 1'b1 && r_in_ready[d] === 1'b1);
                if (accepted) begin
                    sel = int'(r_in_sel[d]);
`ifdef MUXN_PIPE_OOR_FLAG_EN
                    exp_q.push_back({sel >= n, pick13(r_in_data[d], sel, n)});
`else
                    exp_q.push_back({1'b0, pick13(r_in_data[d], sel, n)});
`endif
                    sent++;
                end
                if (r_out_valid[d] === 1'b1 && r_out_ready[d] === 1'b1) begin
`ifdef MUXN_PIPE_OOR_FLAG_EN
                    got_w = {r_out_err[d], r_out_data[d]};
`else
                    got_w = {1'b0, r_out_data[d]};
`endif
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_errors++;
                        $display("FAIL rand_extra: NUM_IN %0d got %h with empty scoreboard", n, got_w);
                    end else begin
                        if (got_w !== exp_q[0]) begin
                            n_errors++;
                            $display("FAIL rand_data: NUM_IN %0d result %0d got %h expected %h",
                                     n, recv, got_w, exp_q[0]);
                        end
                        void'(exp_q.pop_front());
                    end
                    recv++;
                end
                stalled = (r_out_valid[d] === 1'b1 && r_out_ready[d] !== 1'b1);
                held = r_out_data[d];
                step();
                if (accepted) r_in_valid[d] = 1'b0;
                cyc++;
            end
            r_in_valid[d]  = 1'b0;
            r_out_ready[d] = 1'b1;
            n_checks++;
            if (recv != NT || exp_q.size() != 0) begin
                n_errors++;
                $display("FAIL rand_count: NUM_IN %0d got %0d results (%0d pending, %0d cycles) expected %0d",
                         n, recv, exp_q.size(), cyc, NT);
            end
            n_checks++;
            if (hold_err != 0 || flight_err != 0) begin
                n_errors++;
                $display("FAIL rand_hold_flight: NUM_IN %0d got hold errors %0d flight errors %0d expected 0/0",
                         n, hold_err, flight_err);
            end
            ghost = 0;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                if (r_out_valid[d] !== 1'b0) ghost++;
                step();
            end
            n_checks++;
            if (ghost != 0) begin
                n_errors++;
                $display("FAIL rand_dup: NUM_IN %0d got %0d extra valid cycles expected 0", n, ghost);
            end
            r_out_ready[d] = 1'b0;
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        rst = 1'b1;
        d4_in_valid = 1'b0; d4_out_ready = 1'b0; d4_in_data = '0; d4_in_sel = '0;
        d5_in_valid = 1'b0; d5_out_ready = 1'b0; d5_in_data = '0; d5_in_sel = '0;
        r_in_valid = '0; r_out_ready = '0; r_in_data = '0; r_in_sel = '0;
        test_reset();
        test_latency();
        test_oor();
        test_back_to_back();
        test_backpressure();
        test_reset_flush();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/muxn_pipe.md
MUXN_PIPE -- requirements
Module: muxn_pipe

Interface
REQ-001 Parameter: WIDTH, default 8, bit width of each data word; SHALL be >= 1.
REQ-002 Parameter: NUM_IN, default 4, number of input words; SHALL be >= 2.
REQ-003 Localparam: SEL_W = $clog2(NUM_IN), select width and pipeline depth.
REQ-004 Clocking: one clock; reset is synchronous and active-high.
REQ-005 Port: clk  input  1  rising-edge clock.
REQ-006 Port: rst  input  1  synchronous active-high reset.
REQ-007 Port: in_valid  input  1  input transaction present.
REQ-008 Port: in_ready  output  1  block accepts input this cycle.
REQ-009 Port: in_data  input  NUM_IN*WIDTH  word i at bits [i*WIDTH +: WIDTH].
REQ-010 Port: in_sel  input  SEL_W  index of the word to select.
REQ-011 Port: out_valid  output  1  out_data holds a result.
REQ-012 Port: out_ready  input  1  consumer accepts the result.
REQ-013 Port: out_data  output  WIDTH  selected word.
REQ-014 Port: out_err  output  1  select out of range; present only with MUXN_PIPE_OOR_FLAG_EN.

Function
REQ-015 The block SHALL implement a binary 2:1-mux tree of SEL_W levels; level k (k=0 is the leaf level) SHALL use select bit k, LSB first.
REQ-016 Every 2:1 mux bit SHALL be formed as y = ((a ^ b) & s) ^ a; no behavioural ?:, case or $mux SHALL appear in the datapath, so each bit costs exactly one AND.
REQ-017 For non-power-of-2 NUM_IN, missing leaves SHALL be constant zero; in_sel >= NUM_IN SHALL yield out_data = 0.
REQ-018 Each tree level SHALL be followed by one register stage holding the partial words, the unused select bits and a valid bit; latency from accept to out_valid SHALL be exactly SEL_W cycles.
REQ-019 Input is accepted on cycles where in_valid && in_ready; output is consumed on cycles where out_valid && out_ready.
REQ-020 Stage k SHALL load when it is empty or when stage k+1 loads or the output is consumed in the same cycle (bubble-collapsing); in_ready SHALL equal the stage-0 load condition and SHALL be combinational from out_ready.
REQ-021 Sustained throughput SHALL be one transaction per cycle while out_ready = 1.
REQ-022 While out_valid && !out_ready, out_data (and out_err) SHALL be held stable; no transaction SHALL be lost or duplicated; at most SEL_W transactions SHALL be in flight.
REQ-023 Results SHALL leave in acceptance order.
REQ-024 Data registers need no reset; only valid bits are reset.

Reset
REQ-025 While rst = 1 at a clock edge, all stage valid bits SHALL clear; the next cycle out_valid = 0, out_err = 0, and in_ready = 1.
REQ-026 Reset mid-operation SHALL discard all in-flight transactions; no result accepted before reset SHALL appear after it.
REQ-027 in_ready SHALL be 0 during any cycle in which rst = 1.

Configuration
REQ-028 Macro MUXN_PIPE_OOR_FLAG_EN defined: port out_err SHALL exist and carry a per-transaction flag computed at acceptance as (in_sel >= NUM_IN), piped alongside the data, valid only when out_valid = 1, and 0 on reset.
REQ-029 Macro MUXN_PIPE_OOR_FLAG_EN undefined: out_err and its flag registers SHALL not exist; all other behaviour SHALL be identical.
REQ-030 When NUM_IN is a power of 2, out_err SHALL be constant 0.

Verification
REQ-031 WIDTH=8, NUM_IN=4, in_data={8'h44,8'h33,8'h22,8'h11}, in_sel=2, out_ready=1 -> out_valid=1 and out_data=8'h33 exactly 2 cycles after acceptance.
REQ-032 NUM_IN=5, WIDTH=8, in_sel=6 -> out_data=8'h00; out_err=1 with macro; in_sel=4 -> word 4, out_err=0.
REQ-033 NUM_IN=4, stream sel 0,1,2,3 back-to-back with out_ready=1 -> one result per cycle, words 0,1,2,3 in order; in_ready stays 1.
REQ-034 NUM_IN=4, out_ready=0 for 6 cycles with in_valid=1 -> exactly 2 accepted, then in_ready=0, out_data stable; on out_ready=1 both drain in order.
REQ-035 Accept 2 transactions, assert rst 1 cycle before the first emerges -> out_valid=0 the next cycle, no result emerges, and in_ready=1 after reset.
REQ-036 Random: 10k transactions, WIDTH=13, NUM_IN in {2,3,7,8}, random valid/ready -> scoreboard match, no loss, no duplication, no reordering.
